// File: rtl/poly_diff_engine_pkg.sv
// Shared constants and state encoding for the forward-difference polynomial engine.
package poly_diff_engine_pkg;

   localparam int ACC_W  = 24;
   localparam int ANS_W  = 20;
   localparam int N_W    = 6;
   localparam int COEF_W = 8;

   // Largest value the 6-digit BCD display stage can show.
   localparam int unsigned DISP_MAX = 999999;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OP   = 1'b1
   } state_t;

endpackage

// File: rtl/poly_diff_engine.sv
// Evaluates a cubic f(n) by forward differencing: one add stage per step, result
// saturated to the display range, handed to the downstream bin2bcd via done_tick.
module poly_diff_engine
   import poly_diff_engine_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N_W-1:0]    n,
   input  logic [COEF_W-1:0] f0,
   input  logic [COEF_W-1:0] g0,
   input  logic [COEF_W-1:0] h0,
   input  logic [COEF_W-1:0] c3,
   output logic [ANS_W-1:0]  ans,
   output logic              ovf,
   output logic              ready,
   output logic              done_tick
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_f;
   logic [ACC_W-1:0]   r_g;
   logic [ACC_W-1:0]   r_h;
   logic [ACC_W-1:0]   r_c;
   logic [N_W-1:0]     r_i;
   logic [ANS_W-1:0]   r_ans;
   logic               r_ovf;
   logic               w_sat_ovf;
   logic [ANS_W-1:0]   w_sat_ans;

   always_comb begin
      w_sat_ovf = (r_f > ACC_W'(DISP_MAX));
      w_sat_ans = w_sat_ovf ? ANS_W'(DISP_MAX) : r_f[ANS_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      done_tick   = 1'b0;
      ready       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) w_state_nxt = ST_OP;
         end
         ST_OP: begin
            if (r_i == '0) begin
               done_tick   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f   <= '0;
         r_g   <= '0;
         r_h   <= '0;
         r_c   <= '0;
         r_i   <= '0;
         r_ans <= '0;
         r_ovf <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_f <= ACC_W'(f0);
                  r_g <= ACC_W'(g0);
                  r_h <= ACC_W'(h0);
                  r_c <= ACC_W'(c3);
                  r_i <= n;
               end
            end
            ST_OP: begin
               if (r_i != '0) begin
                  r_f <= r_f + r_g;
                  r_g <= r_g + r_h;
                  r_h <= r_h + r_c;
                  r_i <= r_i - 1'b1;
               end else begin
                  r_ans <= w_sat_ans;
                  r_ovf <= w_sat_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   // Bypass the holding register so the result is already valid in the done_tick cycle.
   assign ans = done_tick ? w_sat_ans : r_ans;
   assign ovf = done_tick ? w_sat_ovf : r_ovf;

endmodule

// File: tb/tb_poly_diff_engine.sv
// Directed bench for poly_diff_engine: closed-form binomial model plus literal checks.
module tb_poly_diff_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  n;
   logic [7:0]  f0, g0, h0, c3;
   logic [19:0] ans;
   logic        ovf, ready, done_tick;

   int checks = 0;
   int errors = 0;

   poly_diff_engine dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n(n),
      .f0(f0), .g0(g0), .h0(h0), .c3(c3),
      .ans(ans), .ovf(ovf), .ready(ready), .done_tick(done_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // f(n) = f0 + g0*C(n,1) + h0*C(n,2) + c3*C(n,3)
   function automatic int poly(input int nn, input int f, input int g, input int h, input int c);
      return f + g*nn + h*(nn*(nn-1)/2) + c*(nn*(nn-1)*(nn-2)/6);
   endfunction

   // Timestamp model: a job accepted at an edge finishes n+1 cycles later.
   int  cyc = 0;
   bit  m_busy = 0;
   int  m_done_at = 0;
   int  m_pend = 0;
   int  m_ans = 0;
   int  m_ovf = 0;

   always @(negedge rst_n) begin
      m_busy = 0;
      m_ans  = 0;
      m_ovf  = 0;
   end

   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         if (m_busy) begin
            if (cyc == m_done_at) begin
               m_busy = 0;
               m_ans  = (m_pend > 999999) ? 999999 : m_pend;
               m_ovf  = (m_pend > 999999) ? 1 : 0;
            end
         end else if (start) begin
            m_busy    = 1;
            m_done_at = cyc + 1 + int'(n);
            m_pend    = poly(int'(n), int'(f0), int'(g0), int'(h0), int'(c3));
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit exp_done;
      exp_done = m_busy && (cyc == m_done_at);
      chk("cmp_done", 32'(done_tick), 32'(exp_done));
      chk("cmp_ready", 32'(ready), 32'(!m_busy));
      if (exp_done) begin
         chk("cmp_ans_done", 32'(ans), 32'((m_pend > 999999) ? 999999 : m_pend));
         chk("cmp_ovf_done", 32'(ovf), 32'((m_pend > 999999) ? 1 : 0));
      end else begin
         chk("cmp_ans_hold", 32'(ans), 32'(m_ans));
         chk("cmp_ovf_hold", 32'(ovf), 32'(m_ovf));
      end
   end

   // Caller is at a negedge; start is dropped one cycle later.
   task automatic run_job(input string nm, input int nn, input int f, input int g, input int h,
                          input int c, input int exp_ans, input int exp_ovf, input int exp_lat);
      int lat = 0;
      bit seen = 0;
      n = 6'(nn); f0 = 8'(f); g0 = 8'(g); h0 = 8'(h); c3 = 8'(c);
      start = 1'b1;
      while (!seen && lat < 200) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (done_tick) seen = 1;
      end
      chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_ans"}, 32'(ans), 32'(exp_ans));
      chk({nm, "_ovf"}, 32'(ovf), 32'(exp_ovf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; n = '0; f0 = '0; g0 = '0; h0 = '0; c3 = '0;
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done_tick), 32'd0);
      chk("rst_ans", 32'(ans), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk); run_job("cube",   5,   0,   1,   6,   6,    125, 0,  6);
      @(negedge clk); run_job("n0",     0, 200,  17,  99,   3,    200, 0,  1);
      @(negedge clk); run_job("n1",     1,  10,   7,   0,   0,     17, 0,  2);
      @(negedge clk); run_job("n3",     3,   5,   2,   3,   1,     21, 0,  4);
      @(negedge clk); run_job("max",   63, 255, 255, 255, 255, 999999, 1, 64);
      @(negedge clk); run_job("bnd25", 63,   0,   0,   0,  25, 992775, 0, 64);
      @(negedge clk); run_job("bnd26", 63,   0,   0,   0,  26, 999999, 1, 64);

      // Start requests during OP and coincident with done_tick must be ignored.
      @(negedge clk);
      n = 6'd4; f0 = 8'd0; g0 = 8'd1; h0 = 8'd6; c3 = 8'd6; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; n = 6'd0; f0 = 8'd200;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ign_done", 32'(done_tick), 32'd1);
      chk("ign_ans", 32'(ans), 32'd64);
      start = 1'b1; n = 6'd0; f0 = 8'd77;
      @(negedge clk); start = 1'b0;
      chk("ign_ready", 32'(ready), 32'd1);
      chk("ign_nodone", 32'(done_tick), 32'd0);
      repeat (3) @(negedge clk);
      chk("ign_hold_ans", 32'(ans), 32'd64);
      chk("ign_hold_ready", 32'(ready), 32'd1);

      // Asynchronous reset at OP cycle 3 of an n=10 job.
      @(negedge clk);
      n = 6'd10; f0 = 8'd1; g0 = 8'd1; h0 = 8'd1; c3 = 8'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd1);
      chk("mid_rst_done", 32'(done_tick), 32'd0);
      chk("mid_rst_ans", 32'(ans), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_job("post_rst", 2, 3, 4, 5, 6, 16, 0, 3);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
